// File: rtl/enc_path_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_mlpolar
// Purpose  : Shared multilevel-polar constants, level sizes and FSM encoding.
// Revision : 1.0
// ============================================================================
package pkg_mlpolar;

  localparam int K_LEVELS   = 10;
  localparam int N          = 256;
  localparam int TOTAL_INFO = 1588;
  localparam int LVL_W      = 4;
  localparam int IDX_W      = 8;
  localparam int SYM_W      = 8;
  localparam int KW         = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    START    = 3'd2,
    WAIT_ENC = 3'd3,
    EMIT     = 3'd4
  } state_t;

  // Info bits carried by each level; the sum must equal TOTAL_INFO.
  function automatic logic [KW-1:0] k_info(input logic [LVL_W-1:0] lvl);
    case (lvl)
      4'd0:    return 9'd12;
      4'd1:    return 9'd40;
      4'd2:    return 9'd96;
      4'd3:    return 9'd150;
      4'd4:    return 9'd200;
      4'd5:    return 9'd220;
      4'd6:    return 9'd230;
      4'd7:    return 9'd240;
      4'd8:    return 9'd144;
      4'd9:    return 9'd256;
      default: return '0;
    endcase
  endfunction

  function automatic logic [LVL_W-1:0] first_lvl();
    logic [LVL_W-1:0] fl;
    logic             found;
    fl    = '0;
    found = 1'b0;
    for (int i = 0; i < K_LEVELS; i++) begin
      if (!found && (k_info(LVL_W'(i)) != '0)) begin
        fl    = LVL_W'(i);
        found = 1'b1;
      end
    end
    return fl;
  endfunction

  // Next level holding info bits; empty levels are skipped.
  function automatic logic [LVL_W-1:0] next_lvl(input logic [LVL_W-1:0] lvl);
    logic [LVL_W-1:0] nxt;
    logic             found;
    nxt   = first_lvl();
    found = 1'b0;
    for (int i = 0; i < K_LEVELS; i++) begin
      if (!found && (i > int'(lvl)) && (k_info(LVL_W'(i)) != '0)) begin
        nxt   = LVL_W'(i);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_path_sched_lvl_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lvl_addr_gen
// Purpose  : Level / bit-index walker for the per-level info buffers.
// Revision : 1.0
// ============================================================================
module lvl_addr_gen
  import pkg_mlpolar::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [LVL_W-1:0] lvl,
  output logic [IDX_W-1:0] idx
);

  logic [LVL_W-1:0] r_lvl;
  logic [IDX_W-1:0] r_idx;
  logic             w_wrap;

  assign w_wrap = ({1'b0, r_idx} == (k_info(r_lvl) - KW'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_lvl <= first_lvl();
      r_idx <= '0;
    end else if (step) begin
      if (w_wrap) begin
        r_idx <= '0;
        r_lvl <= next_lvl(r_lvl);
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign lvl = r_lvl;
  assign idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/enc_path_sched.sv
`default_nettype none
// ============================================================================
// Module   : enc_path_sched
// Purpose  : Serial info loader, polar-encoder kick-off and PPM column emitter.
// Revision : 1.0
// ============================================================================
module enc_path_sched #(
  parameter int TOTAL_INFO  = pkg_mlpolar::TOTAL_INFO,
  parameter int ENC_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          info_bit,
  input  logic                          info_valid,
  output logic                          info_ready,
  output logic                          lvl_wr_en,
  output logic [pkg_mlpolar::LVL_W-1:0] lvl_sel,
  output logic [pkg_mlpolar::IDX_W-1:0] lvl_wr_idx,
  output logic                          lvl_wr_bit,
  output logic                          enc_start,
  input  logic                          enc_done,
  output logic [pkg_mlpolar::SYM_W-1:0] sym_idx,
  output logic                          ppm_valid_out,
  input  logic                          ppm_ready_in,
  output logic                          block_done,
  output logic [15:0]                   blk_cnt,
  output logic                          err
);

  import pkg_mlpolar::*;

  localparam int CNT_W = $clog2(TOTAL_INFO + 1);
  localparam int TMO_W = $clog2(ENC_TIMEOUT + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_tot_cnt;
  logic [TMO_W-1:0]   r_tmo;
  logic [SYM_W-1:0]   r_sym;
  logic               r_enc_start;
  logic               r_ppm_valid;
  logic               r_block_done;
  logic [15:0]        r_blk_cnt;
  logic               r_err;

  logic               w_ready;
  logic               w_accept;
  logic               w_last;
  logic               w_hs;
  logic [LVL_W-1:0]   w_lvl;
  logic [IDX_W-1:0]   w_idx;

  // The block_done cycle is already IDLE but still belongs to the old block.
  assign w_ready  = rst_n && ((r_state == IDLE) || (r_state == LOAD)) && !r_block_done;
  assign w_accept = w_ready && info_valid;
  assign w_last   = w_accept && (r_tot_cnt == CNT_W'(TOTAL_INFO - 1));
  assign w_hs     = r_ppm_valid && ppm_ready_in;

  lvl_addr_gen u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_last),
    .step  (w_accept),
    .lvl   (w_lvl),
    .idx   (w_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tot_cnt    <= '0;
      r_tmo        <= '0;
      r_sym        <= '0;
      r_enc_start  <= 1'b0;
      r_ppm_valid  <= 1'b0;
      r_block_done <= 1'b0;
      r_blk_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_enc_start  <= 1'b0;
      r_block_done <= 1'b0;
      if (enc_done && (r_state != WAIT_ENC)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            if (w_last) begin
              r_state     <= START;
              r_tot_cnt   <= '0;
              r_enc_start <= 1'b1;
            end else begin
              r_state   <= LOAD;
              r_tot_cnt <= r_tot_cnt + CNT_W'(1);
            end
          end
        end
        START: begin
          r_state <= WAIT_ENC;
          r_tmo   <= '0;
        end
        WAIT_ENC: begin
          if (enc_done) begin
            r_state     <= EMIT;
            r_sym       <= '0;
            r_ppm_valid <= 1'b1;
          end else if (r_tmo == TMO_W'(ENC_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        EMIT: begin
          if (w_hs) begin
            if (r_sym == SYM_W'(N - 1)) begin
              r_state      <= IDLE;
              r_sym        <= '0;
              r_ppm_valid  <= 1'b0;
              r_block_done <= 1'b1;
              r_blk_cnt    <= r_blk_cnt + 16'd1;
            end else begin
              r_sym <= r_sym + SYM_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign info_ready    = w_ready;
  assign lvl_wr_en     = w_accept;
  assign lvl_sel       = w_lvl;
  assign lvl_wr_idx    = w_idx;
  assign lvl_wr_bit    = info_bit;
  assign enc_start     = r_enc_start;
  assign sym_idx       = r_sym;
  assign ppm_valid_out = r_ppm_valid;
  assign block_done    = r_block_done;
  assign blk_cnt       = r_blk_cnt;
  assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_enc_path_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_path_sched
// Purpose  : Randomized scoreboard bench for enc_path_sched.
// Revision : 1.0
// ============================================================================
module tb_enc_path_sched;

  localparam int TOTAL = 1588;
  localparam int TMO   = 15;

  typedef struct packed {
    logic [3:0] lvl;
    logic [7:0] idx;
    logic       b;
  } wr_t;

  logic        clk, rst_n, info_bit, info_valid, info_ready, lvl_wr_en, lvl_wr_bit;
  logic [3:0]  lvl_sel;
  logic [7:0]  lvl_wr_idx, sym_idx;
  logic        enc_start, enc_done, enc_done_m, enc_done_g;
  logic        ppm_valid_out, ppm_ready_in, block_done, err;
  logic [15:0] blk_cnt;

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   rdy_mode = 0;
  bit   enc_hold_off = 0;
  int   tb_k [10] = '{12, 40, 96, 150, 200, 220, 230, 240, 144, 256};
  wr_t  q_wr [$];
  logic [7:0] q_sym [$];

  assign enc_done = enc_done_m | enc_done_g;

  enc_path_sched #(.TOTAL_INFO(TOTAL), .ENC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .info_bit(info_bit), .info_valid(info_valid),
    .info_ready(info_ready), .lvl_wr_en(lvl_wr_en), .lvl_sel(lvl_sel),
    .lvl_wr_idx(lvl_wr_idx), .lvl_wr_bit(lvl_wr_bit), .enc_start(enc_start),
    .enc_done(enc_done), .sym_idx(sym_idx), .ppm_valid_out(ppm_valid_out),
    .ppm_ready_in(ppm_ready_in), .block_done(block_done), .blk_cnt(blk_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no response expected an event at %0t", name, $time);
  endtask

  // Ordinal n within a block -> (level, index), by walking the level sizes.
  function automatic void addr_of(input int n, output int lvl, output int idx);
    int rem;
    rem = n;
    lvl = 0;
    while (rem >= tb_k[lvl]) begin
      rem -= tb_k[lvl];
      lvl++;
    end
    idx = rem;
  endfunction

  task automatic send_block(input bit gaps);
    int  lvl, idx, guard;
    bit  b, acc;
    wr_t e;
    for (int n = 0; n < TOTAL; n++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          info_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      b = 1'($urandom_range(0, 1));
      addr_of(n, lvl, idx);
      e.lvl = 4'(lvl);
      e.idx = 8'(idx);
      e.b   = b;
      q_wr.push_back(e);
      info_bit   = b;
      info_valid = 1'b1;
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 6000) begin
        @(negedge clk);
        acc = (info_ready === 1'b1);
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        note_fail("accept_timeout");
        info_valid = 1'b0;
        return;
      end
    end
    info_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0, c;
    n0 = n_done;
    c  = 0;
    while (n_done == n0 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_block_done_seen"}, 32'(n_done != n0), 1);
    @(posedge clk); #1;
  endtask

  // Downstream ready pattern.
  initial begin
    int cyc;
    cyc = 0;
    ppm_ready_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0:       ppm_ready_in = 1'b1;
        1:       ppm_ready_in = ((cyc / 3) % 2) == 0;
        default: ppm_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Encoder stand-in: answers enc_start after a random legal latency.
  initial begin
    enc_done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && enc_start === 1'b1 && !enc_hold_off) begin
        int d;
        d = $urandom_range(1, TMO);
        repeat (d) @(posedge clk);
        #1;
        enc_done_m = 1'b1;
        for (int i = 0; i < 256; i++) q_sym.push_back(8'(i));
        @(posedge clk); #1;
        enc_done_m = 1'b0;
      end
    end
  end

  // Monitor and reference model.
  initial begin
    bit   busy, start_due, done_due, waiting, emit, exp_err, prev_stall, rst_prev;
    bit   start_nx, done_nx;
    int   acc, k, exp_blk;
    logic [7:0] prev_sym, s;
    wr_t  e;
    busy = 0; start_due = 0; done_due = 0; waiting = 0; emit = 0;
    exp_err = 0; prev_stall = 0; rst_prev = 0;
    acc = 0; k = 0; exp_blk = 0; prev_sym = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        chk("rst_info_ready", 32'(info_ready), 0);
        chk("rst_lvl_wr_en", 32'(lvl_wr_en), 0);
        if (rst_prev) begin
          chk("rst_enc_start", 32'(enc_start), 0);
          chk("rst_ppm_valid", 32'(ppm_valid_out), 0);
          chk("rst_block_done", 32'(block_done), 0);
          chk("rst_sym_idx", 32'(sym_idx), 0);
          chk("rst_err", 32'(err), 0);
          chk("rst_blk_cnt", 32'(blk_cnt), 0);
        end
        busy = 0; start_due = 0; done_due = 0; waiting = 0; emit = 0;
        exp_err = 0; prev_stall = 0; acc = 0; k = 0; exp_blk = 0;
        q_wr.delete();
        q_sym.delete();
        rst_prev = 1;
        continue;
      end
      rst_prev = 0;

      chk("info_ready", 32'(info_ready), 32'(!busy));
      chk("lvl_wr_en", 32'(lvl_wr_en), 32'(info_valid && !busy));
      chk("enc_start", 32'(enc_start), 32'(start_due));
      chk("ppm_valid_out", 32'(ppm_valid_out), 32'(emit));
      chk("block_done", 32'(block_done), 32'(done_due));
      chk("blk_cnt", 32'(blk_cnt), 32'(exp_blk));
      chk("err", 32'(err), 32'(exp_err));
      if (emit && prev_stall) chk("sym_hold", 32'(sym_idx), 32'(prev_sym));
      if (block_done === 1'b1) n_done++;

      prev_stall = emit && !ppm_ready_in;
      prev_sym   = sym_idx;
      start_nx   = 0;
      done_nx    = 0;

      if (info_valid && !busy) begin
        if (q_wr.size() == 0) note_fail("wr_queue_empty");
        else begin
          e = q_wr.pop_front();
          chk("lvl_sel", 32'(lvl_sel), 32'(e.lvl));
          chk("lvl_wr_idx", 32'(lvl_wr_idx), 32'(e.idx));
          chk("lvl_wr_bit", 32'(lvl_wr_bit), 32'(e.b));
        end
        acc++;
        if (acc == TOTAL) begin
          acc = 0;
          busy = 1;
          start_nx = 1;
        end
      end

      if (emit && ppm_ready_in) begin
        if (q_sym.size() == 0) note_fail("sym_queue_empty");
        else begin
          s = q_sym.pop_front();
          chk("sym_idx", 32'(sym_idx), 32'(s));
          if (s == 8'hFF) begin
            emit = 0;
            done_nx = 1;
            exp_blk = (exp_blk + 1) % 65536;
          end
        end
      end

      if (done_due) begin
        chk("sym_drained", 32'(q_sym.size()), 0);
        busy = 0;
      end

      if (enc_done === 1'b1) begin
        if (waiting) begin
          waiting = 0;
          emit = 1;
        end else begin
          exp_err = 1;
        end
      end else if (waiting) begin
        k++;
        if (k == TMO) begin
          waiting = 0;
          exp_err = 1;
          busy = 0;
        end
      end

      if (start_due) begin
        waiting = 1;
        k = 0;
      end
      start_due = start_nx;
      done_due  = done_nx;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, guard;
    bit hit;
    rst_n = 1'b0; info_bit = 1'b0; info_valid = 1'b0; enc_done_g = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous stream, always-ready sink.
    rdy_mode = 0;
    send_block(1'b0);
    wait_done("blk1");
    chk("blk1_blk_cnt", 32'(blk_cnt), 1);

    // Input gaps, sink toggling every 3 cycles.
    rdy_mode = 1;
    send_block(1'b1);
    wait_done("blk2");
    chk("blk2_blk_cnt", 32'(blk_cnt), 2);

    // Encoder never answers: timeout path.
    rdy_mode = 2;
    enc_hold_off = 1;
    n0 = n_done;
    send_block(1'b0);
    repeat (TMO + 5) @(posedge clk);
    @(negedge clk);
    chk("timeout_err", 32'(err), 1);
    chk("timeout_info_ready", 32'(info_ready), 1);
    chk("timeout_no_block_done", 32'(n_done - n0), 0);
    chk("timeout_blk_cnt", 32'(blk_cnt), 2);
    @(posedge clk); #1;
    enc_hold_off = 0;

    // Reset while idle clears err and blk_cnt.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Stray enc_done while loading.
    rdy_mode = 2;
    fork
      send_block(1'b1);
      begin
        repeat (400) @(posedge clk);
        #1 enc_done_g = 1'b1;
        @(posedge clk); #1 enc_done_g = 1'b0;
      end
    join
    wait_done("blk3");
    chk("glitch_err", 32'(err), 1);
    chk("blk3_blk_cnt", 32'(blk_cnt), 1);

    // Reset in the middle of symbol emission.
    rdy_mode = 0;
    send_block(1'b0);
    hit = 0;
    guard = 0;
    while (!hit && guard < 3000) begin
      @(negedge clk);
      hit = (ppm_valid_out === 1'b1) && (sym_idx == 8'd100);
      guard++;
    end
    if (!hit) note_fail("reach_sym100");
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 2;
    send_block(1'b1);
    wait_done("blk_after_reset");
    chk("after_reset_blk_cnt", 32'(blk_cnt), 1);
    chk("after_reset_err", 32'(err), 0);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc_path_sched.md
ENC_PATH_SCHED -- requirements
Module: enc_path_sched

Interface
REQ-001 SHALL have parameter TOTAL_INFO, default 1588, meaning info bits per block (equals sum of K_INFO).
REQ-002 SHALL have parameter ENC_TIMEOUT, default 15, meaning max cycles from enc_start to enc_done.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 info_bit  in  1  serial info bit.
REQ-006 info_valid  in  1  info_bit is valid.
REQ-007 info_ready  out  1  scheduler accepts an info bit this cycle.
REQ-008 lvl_wr_en  out  1  write strobe to level info buffer.
REQ-009 lvl_sel  out  4  target level 0..K_LEVELS-1.
REQ-010 lvl_wr_idx  out  8  bit index within level buffer.
REQ-011 lvl_wr_bit  out  1  bit to write.
REQ-012 enc_start  out  1  one-cycle start pulse to all polar encoders.
REQ-013 enc_done  in  1  encoder valid_out (level 0).
REQ-014 sym_idx  out  8  codeword column n selecting the PPM slot {c_0[n]..c_9[n]}.
REQ-015 ppm_valid_out  out  1  sym_idx is valid.
REQ-016 ppm_ready_in  in  1  downstream accepts the symbol.
REQ-017 block_done  out  1  one-cycle pulse after last symbol is accepted.
REQ-018 blk_cnt  out  16  completed blocks, wraps 0xFFFF->0.
REQ-019 err  out  1  sticky error flag.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, START, WAIT_ENC, EMIT.
REQ-021 info_ready SHALL be 1 only in IDLE and LOAD; an accept is info_valid && info_ready.
REQ-022 Each accept SHALL drive lvl_wr_en=1, lvl_wr_bit=info_bit, lvl_sel/lvl_wr_idx = current level/index, combinationally in the same cycle.
REQ-023 First accept SHALL move IDLE->LOAD; the index increments per accept; at index K_INFO[lvl]-1 the index clears and the level advances to the next level with K_INFO>0.
REQ-024 A global counter SHALL count accepts; the accept making it TOTAL_INFO SHALL move the FSM to START and clear the level, index and counter.
REQ-025 START SHALL last exactly one cycle with enc_start=1, then go to WAIT_ENC; enc_start SHALL be 0 in all other states.
REQ-026 In WAIT_ENC, enc_done=1 SHALL move the FSM to EMIT with sym_idx=0; if ENC_TIMEOUT cycles pass without enc_done, the block SHALL set err and return to IDLE without a block_done pulse.
REQ-027 enc_done outside WAIT_ENC SHALL be ignored and SHALL set err.
REQ-028 In EMIT, ppm_valid_out SHALL be 1 and sym_idx SHALL be held stable until ppm_valid_out && ppm_ready_in; each handshake increments sym_idx.
REQ-029 The handshake at sym_idx=N-1 (255) SHALL, on the next cycle, give block_done=1 for one cycle, blk_cnt+1, ppm_valid_out=0 and state IDLE.
REQ-030 ppm_ready_in held low SHALL stall EMIT indefinitely; no symbol is skipped or repeated.
REQ-031 Info bits SHALL NOT be accepted from START through the block_done cycle (no overlap between blocks).
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all counters, blk_cnt and err.
REQ-034 During reset, outputs SHALL be info_ready=0, lvl_wr_en=0, enc_start=0, ppm_valid_out=0, block_done=0 and sym_idx=0.
REQ-035 A reset in any state, including mid-LOAD or mid-EMIT, SHALL discard the partial block; the first cycle after release SHALL be IDLE with info_ready=1.

Structure
REQ-036 K_LEVELS, N, K_INFO[], TOTAL_INFO and the FSM state enum SHALL live in pkg_mlpolar.
REQ-037 No sub-module is required; the level/index counter MAY be factored as lvl_addr_gen.

Verification
REQ-038 Stream 1588 bits, valid=1 continuously, ready_in=1 -> enc_start exactly 1 cycle after the 1588th accept; 256 symbols with sym_idx 0..255; block_done once; blk_cnt=1.
REQ-039 Level boundary: after K_INFO[0] accepts -> lvl_sel 0->1 and lvl_wr_idx 0 on the next accept; last accept has lvl_sel=9 and lvl_wr_idx=K_INFO[9]-1.
REQ-040 Toggle ppm_ready_in every 3 cycles during EMIT -> sym_idx stable while stalled; exactly 256 handshakes, no gaps or duplicates.
REQ-041 Hold enc_done low after enc_start -> err=1 after 15 cycles, state IDLE, info_ready=1, no block_done.
REQ-042 Assert rst_n=0 at sym_idx=100 -> next cycle all outputs at reset values; a following full block completes with blk_cnt=1.
REQ-043 Pulse enc_done while in LOAD -> err=1 and the LOAD count continues unaffected.
